// File: rtl/adder_sched_pkg.sv
// rtl/adder_sched_pkg.sv - shared types, widths and round-robin pick for adder32_rr_sched
package adder_sched_pkg;

   localparam int WORD_W  = 32;
   localparam int HALF_W  = 16;
   localparam int MAX_REQ = 8;

   typedef enum logic [1:0] {
      IDLE,
      LO,
      HI,
      RESP
   } state_t;

   // First set bit at or above ptr, wrapping modulo n; -1 when nothing is valid.
   // Walking downward lets the nearest candidate overwrite the farther ones without a break.
   function automatic int rr_pick(input logic [MAX_REQ-1:0] valid, input int ptr, input int n);
      int idx;
      rr_pick = -1;
      for (int k = n - 1; k >= 0; k--) begin
         idx = (ptr + k) % n;
         if (valid[idx[2:0]]) begin
            rr_pick = idx;
         end
      end
   endfunction

endpackage

// File: rtl/adder16_slice.sv
// rtl/adder16_slice.sv - combinational 16-bit carry-lookahead adder slice
module adder16_slice
   import adder_sched_pkg::*;
(
   input  logic [HALF_W-1:0] a,
   input  logic [HALF_W-1:0] b,
   input  logic              ci,
   output logic [HALF_W-1:0] s,
   output logic              co
);

   logic [HALF_W-1:0] g;
   logic [HALF_W-1:0] p;
   logic [HALF_W-1:0] c;
   logic [3:0]        gg;
   logic [3:0]        gp;
   logic [4:0]        gc;

   always_comb begin
      g = a & b;
      p = a ^ b;

      for (int k = 0; k < 4; k++) begin
         gg[k] = g[4*k+3]
               | (p[4*k+3] & g[4*k+2])
               | (p[4*k+3] & p[4*k+2] & g[4*k+1])
               | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
         gp[k] = &p[4*k +: 4];
      end

      // Group carries are fully expanded so no group waits on its neighbour.
      gc[0] = ci;
      gc[1] = gg[0] | (gp[0] & ci);
      gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & ci);
      gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
            | (gp[2] & gp[1] & gp[0] & ci);
      gc[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
            | (gp[3] & gp[2] & gp[1] & gg[0])
            | (gp[3] & gp[2] & gp[1] & gp[0] & ci);

      for (int k = 0; k < 4; k++) begin
         c[4*k]   = gc[k];
         c[4*k+1] = g[4*k] | (p[4*k] & gc[k]);
         c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & gc[k]);
         c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k])
                  | (p[4*k+2] & p[4*k+1] & p[4*k] & gc[k]);
      end

      s  = p ^ c;
      co = gc[4];
   end

endmodule

// File: rtl/adder32_rr_sched.sv
// rtl/adder32_rr_sched.sv - round-robin scheduler sharing one 16-bit slice for 32-bit add/sub
module adder32_rr_sched
   import adder_sched_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int IDW  = $clog2(NREQ)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [NREQ-1:0]        req_valid,
   input  logic [NREQ*WORD_W-1:0] req_a,
   input  logic [NREQ*WORD_W-1:0] req_b,
   input  logic [NREQ-1:0]        req_sub,
   output logic [NREQ-1:0]        req_ready,
   output logic                   resp_valid,
   input  logic                   resp_ready,
   output logic [WORD_W-1:0]      resp_sum,
   output logic                   resp_cout,
   output logic [IDW-1:0]         resp_id,
   output logic                   busy
);

   state_t              state;
   logic [WORD_W-1:0]   a_r;
   logic [WORD_W-1:0]   b_r;
   logic [WORD_W-1:0]   sum_r;
   logic                cin_r;
   logic                carry16;
   logic                cout_r;
   logic [IDW-1:0]      id_r;
   logic [IDW-1:0]      rr_ptr;

   logic [MAX_REQ-1:0]  valid_ext;
   int                  win_idx;
   logic                win_found;
   logic [IDW-1:0]      win_id;
   logic [WORD_W-1:0]   win_a;
   logic [WORD_W-1:0]   win_b;
   logic                win_sub;

   logic [HALF_W-1:0]   sl_a;
   logic [HALF_W-1:0]   sl_b;
   logic                sl_ci;
   logic [HALF_W-1:0]   sl_s;
   logic                sl_co;

   always_comb begin
      valid_ext = '0;
      valid_ext[NREQ-1:0] = req_valid;
      win_idx   = rr_pick(valid_ext, int'(rr_ptr), NREQ);
      win_found = (win_idx >= 0);
      win_id    = IDW'(win_idx);
      win_a     = req_a[WORD_W*win_id +: WORD_W];
      win_b     = req_b[WORD_W*win_id +: WORD_W];
      win_sub   = req_sub[win_id];

      // Grant is never shown while reset is asserted, even though state reads IDLE.
      req_ready = '0;
      if (rst_n && (state == IDLE) && win_found) begin
         req_ready[win_id] = 1'b1;
      end
   end

   always_comb begin
      if (state == HI) begin
         sl_a  = a_r[WORD_W-1:HALF_W];
         sl_b  = b_r[WORD_W-1:HALF_W];
         sl_ci = carry16;
      end else begin
         sl_a  = a_r[HALF_W-1:0];
         sl_b  = b_r[HALF_W-1:0];
         sl_ci = cin_r;
      end
   end

   adder16_slice u_slice (
      .a  (sl_a),
      .b  (sl_b),
      .ci (sl_ci),
      .s  (sl_s),
      .co (sl_co)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= IDLE;
         rr_ptr  <= '0;
         a_r     <= '0;
         b_r     <= '0;
         cin_r   <= 1'b0;
         carry16 <= 1'b0;
         sum_r   <= '0;
         cout_r  <= 1'b0;
         id_r    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (win_found) begin
                  // Subtract is A + ~B + 1: invert B here and feed the +1 as the low carry-in.
                  a_r   <= win_a;
                  b_r   <= win_sub ? ~win_b : win_b;
                  cin_r <= win_sub;
                  id_r  <= win_id;
                  state <= LO;
               end
            end
            LO: begin
               sum_r[HALF_W-1:0] <= sl_s;
               carry16           <= sl_co;
               state             <= HI;
            end
            HI: begin
               sum_r[WORD_W-1:HALF_W] <= sl_s;
               cout_r                 <= sl_co;
               state                  <= RESP;
            end
            RESP: begin
               if (resp_ready) begin
                  rr_ptr <= (id_r == IDW'(NREQ - 1)) ? '0 : id_r + 1'b1;
                  state  <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign resp_valid = (state == RESP);
   assign resp_sum   = sum_r;
   assign resp_cout  = cout_r;
   assign resp_id    = id_r;
   assign busy       = (state != IDLE);

endmodule

// File: tb/tb_adder32_rr_sched.sv
// tb/tb_adder32_rr_sched.sv - self-checking bench for adder32_rr_sched
module tb_adder32_rr_sched;

   localparam int NREQ = 4;
   localparam int IDW  = 2;

   logic                 clk = 1'b0;
   logic                 rst_n;
   logic [NREQ-1:0]      req_valid;
   logic [NREQ*32-1:0]   req_a;
   logic [NREQ*32-1:0]   req_b;
   logic [NREQ-1:0]      req_sub;
   logic [NREQ-1:0]      req_ready;
   logic                 resp_valid;
   logic                 resp_ready;
   logic [31:0]          resp_sum;
   logic                 resp_cout;
   logic [IDW-1:0]       resp_id;
   logic                 busy;

   int errors = 0;
   int checks = 0;
   int model_ptr = 0;
   logic [31:0] op_a [NREQ];
   logic [31:0] op_b [NREQ];
   logic        op_sub [NREQ];
   int grants[$];

   always #5 clk = ~clk;

   adder32_rr_sched #(.NREQ(NREQ), .IDW(IDW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_a      (req_a),
      .req_b      (req_b),
      .req_sub    (req_sub),
      .req_ready  (req_ready),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_sum   (resp_sum),
      .resp_cout  (resp_cout),
      .resp_id    (resp_id),
      .busy       (busy)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_ops();
      for (int i = 0; i < NREQ; i++) begin
         req_a[32*i +: 32] = op_a[i];
         req_b[32*i +: 32] = op_b[i];
         req_sub[i]        = op_sub[i];
      end
   endtask

   function automatic int model_pick(input logic [NREQ-1:0] mask);
      for (int k = 0; k < NREQ; k++) begin
         if (mask[(model_ptr + k) % NREQ]) return (model_ptr + k) % NREQ;
      end
      return -1;
   endfunction

   task automatic check_reset_outputs(input string tag);
      check({tag, "_ready"}, req_ready, 0);
      check({tag, "_valid"}, resp_valid, 0);
      check({tag, "_sum"}, resp_sum, 0);
      check({tag, "_cout"}, resp_cout, 0);
      check({tag, "_id"}, resp_id, 0);
      check({tag, "_busy"}, busy, 0);
   endtask

   task automatic do_reset();
      rst_n      = 1'b0;
      req_valid  = '0;
      resp_ready = 1'b0;
      step();
      step();
      check_reset_outputs("rst");
      rst_n     = 1'b1;
      model_ptr = 0;
   endtask

   // One full operation from an IDLE cycle; delay = RESP cycles with resp_ready low.
   task automatic run_txn(input logic [NREQ-1:0] mask, input int delay, input bit hold);
      int          w;
      logic [63:0] wide;
      logic [31:0] esum;
      logic        ecout;
      w = model_pick(mask);
      if (op_sub[w]) begin
         esum  = op_a[w] - op_b[w];
         ecout = (op_a[w] >= op_b[w]);
      end else begin
         wide  = 64'(op_a[w]) + 64'(op_b[w]);
         esum  = wide[31:0];
         ecout = wide[32];
      end
      req_valid  = mask;
      resp_ready = (delay == 0);
      drive_ops();
      #1;
      check("idle_busy", busy, 0);
      check("grant", req_ready, 64'(1) << w);
      step();
      grants.push_back(w);
      if (!hold) req_valid = '0;
      for (int i = 0; i < NREQ; i++) begin
         op_a[i]   = $urandom;
         op_b[i]   = $urandom;
         op_sub[i] = 1'($urandom_range(1));
      end
      drive_ops();
      check("lo_ready", req_ready, 0);
      check("lo_busy", busy, 1);
      check("lo_valid", resp_valid, 0);
      step();
      check("hi_valid", resp_valid, 0);
      check("hi_ready", req_ready, 0);
      step();
      check("resp_valid", resp_valid, 1);
      check("resp_sum", resp_sum, esum);
      check("resp_cout", resp_cout, ecout);
      check("resp_id", resp_id, w);
      if (delay > 0) req_valid = '1;
      for (int d = 0; d < delay; d++) begin
         step();
         check("bp_valid", resp_valid, 1);
         check("bp_sum", resp_sum, esum);
         check("bp_cout", resp_cout, ecout);
         check("bp_id", resp_id, w);
         check("bp_ready", req_ready, 0);
      end
      req_valid  = hold ? mask : '0;
      resp_ready = 1'b1;
      step();
      check("done_valid", resp_valid, 0);
      check("done_busy", busy, 0);
      model_ptr = (w + 1) % NREQ;
   endtask

   task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b, input logic s);
      op_a[i]   = a;
      op_b[i]   = b;
      op_sub[i] = s;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      int exp_order[5];
      logic [NREQ-1:0] m;
      exp_order = '{0, 1, 2, 3, 0};
      req_a   = '0;
      req_b   = '0;
      req_sub = '0;
      for (int i = 0; i < NREQ; i++) set_op(i, 32'h0, 32'h0, 1'b0);
      #2;
      do_reset();

      set_op(0, 32'h0000_0005, 32'h0000_0007, 1'b0);
      run_txn(4'b0001, 0, 1'b0);
      set_op(1, 32'h0000_FFFF, 32'h0000_0001, 1'b0);
      run_txn(4'b0010, 0, 1'b0);
      set_op(2, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
      run_txn(4'b0100, 0, 1'b0);
      set_op(3, 32'h0000_0005, 32'h0000_0007, 1'b1);
      run_txn(4'b1000, 0, 1'b0);
      set_op(0, 32'h0000_0007, 32'h0000_0005, 1'b1);
      run_txn(4'b0001, 5, 1'b0);
      set_op(2, 32'h1234_5678, 32'h1234_5678, 1'b1);
      run_txn(4'b0100, 1, 1'b0);

      do_reset();
      grants.delete();
      for (int n = 0; n < 5; n++) begin
         for (int i = 0; i < NREQ; i++) set_op(i, $urandom, $urandom, 1'($urandom_range(1)));
         run_txn(4'b1111, 0, 1'b1);
      end
      req_valid = '0;
      for (int n = 0; n < 5; n++) check("rr_order", grants[n], exp_order[n]);

      set_op(2, 32'hDEAD_BEEF, 32'h0000_1111, 1'b0);
      req_valid  = 4'b0100;
      resp_ready = 1'b1;
      drive_ops();
      step();
      req_valid = '0;
      step();
      check("midhi_busy", busy, 1);
      rst_n = 1'b0;
      step();
      check_reset_outputs("midhi");
      rst_n     = 1'b1;
      model_ptr = 0;
      for (int n = 0; n < 4; n++) begin
         step();
         check("abort_valid", resp_valid, 0);
         check("abort_busy", busy, 0);
      end

      for (int n = 0; n < 25; n++) begin
         for (int i = 0; i < NREQ; i++) set_op(i, $urandom, $urandom, 1'($urandom_range(1)));
         m = 4'($urandom_range(15, 1));
         run_txn(m, $urandom_range(3), 1'b0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
